seq_det_scan: RTL
=================

// Module: seq_det_scan
// PURPOSE
// - Parametrised successor of the 4-bit/2-bit switch sequence detector. It counts how many times a PAT_W-bit pattern occurs in a DATA_W-bit word.
// - Scans one window position per clock, MSB-first. Supports overlapping and non-overlapping counting.
// - Reports the match count and the index of the first match.
// - Sits between the key debounce/edge logic (start pulse) and the seven-segment display driver.
// PARAMETERS
// - DATA_W  4  width of searched word; must be >= PAT_W.
// - PAT_W   2  pattern width; must be >= 1.
// - Derived localparams:
//   - NWIN  = DATA_W-PAT_W+1
//   - CNT_W = $clog2(NWIN+1)
//   - IDX_W = max(1,$clog2(NWIN))
// - An illegal combination fails elaboration via a generate-time $error.
// PORTS
// - clk        in   1      single system clock, all logic on posedge
// - rst_n      in   1      synchronous active-low reset
// - start      in   1      one-cycle request pulse (already edge-detected upstream)
// - mode       in   1      0 = overlapping count, 1 = non-overlapping count
// - pat        in   PAT_W  pattern to find
// - din        in   DATA_W word to search
// - busy       out  1      high while scanning
// - done       out  1      one-cycle pulse, results valid from this cycle on
// - found      out  1      at least one match in last completed scan
// - match_cnt  out  CNT_W  number of matches in last completed scan
// - first_pos  out  IDX_W  position of first match; 0 when found=0
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state IDLE; busy, done, found, match_cnt and first_pos all 0. Reset mid-scan aborts the scan; no done pulse.
// - Window p (0..NWIN-1) = din_q[DATA_W-1-p -: PAT_W]. Position 0 is the MSB end.
// - FSM states: IDLE, SCAN, DONE.
//   - IDLE: on start=1, latch din, pat and mode into din_q, pat_q and mode_q. Clear pos, cnt_acc and first_acc. Go to SCAN.
//   - SCAN: busy=1. Compare window pos with pat_q.
//     - On a match: cnt_acc+1. If this is the first match, first_acc<=pos.
//     - Next pos = pos+PAT_W if (mode_q && match), else pos+1.
//     - If next pos > NWIN-1, go to DONE. Compare in full width so there is no wrap.
//   - DONE: load match_cnt, found (cnt_acc!=0) and first_pos from the accumulators, including the final-cycle match. done=1 and busy=0 for exactly one cycle, then IDLE.
// - Latency (start sampled at edge k):
//   - Overlapping: done high in the cycle after edge k+NWIN.
//   - Non-overlapping: done appears after (positions visited)+1 edges.
// - Result outputs hold their value until the next DONE or reset. They do not change during SCAN.
// - start while busy or in DONE: ignored. din/pat/mode changes during a scan have no effect.
// - Back-to-back: start in the cycle after done is accepted.
// - cnt_acc never overflows, since CNT_W covers NWIN.
// - PAT_W==DATA_W: one window, one SCAN cycle.
// STRUCTURE
// - Shared package seq_det_pkg holds:
//   - state encoding: ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2
//   - clog2/max helper functions used for the CNT_W and IDX_W derivation
// - One sub-module, seq_win_cmp: a combinational window select (indexed part-select by pos) and equality compare. Parameters DATA_W, PAT_W, IDX_W; output hit.
// - Top level holds the FSM, the latches and the accumulators.
// TESTING
// - T1: DATA_W=4, PAT_W=2, din=4'b1111, pat=2'b11, mode=0, start at edge k -> match_cnt=3, found=1, first_pos=0, done at cycle after edge k+3.
// - T2: same stimulus as T1 with mode=1 -> match_cnt=2, first_pos=0, done after edge k+2.
// - T3: din=4'b1010, pat=2'b01 -> match_cnt=1, first_pos=1. Then din=4'b0000, pat=2'b11 -> match_cnt=0, found=0, first_pos=0.
// - T4: DATA_W=8, PAT_W=3, din=8'b10110110, pat=3'b101, for both modes -> match_cnt=2, first_pos=0.
// - T5: start pulses during SCAN and in the DONE cycle are ignored. din changed mid-scan does not alter the result. rst_n=0 mid-scan -> next cycle IDLE, all outputs 0, no done.
// - T6: back-to-back starts (start in cycle after done) -> second result correct. Random din/pat/mode checked against a reference model.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state encoding and the constant helpers used to size the detector's counters
package seq_det_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/seq_win_cmp.sv
// seq_win_cmp: selects window pos (MSB end is 0) of din and flags equality with pat; in din pat pos, out hit
module seq_win_cmp #(
  parameter int DATA_W = 4,
  parameter int PAT_W = 2,
  parameter int IDX_W = 2
) (
  input  logic [DATA_W-1:0] din,
  input  logic [PAT_W-1:0]  pat,
  input  logic [IDX_W-1:0]  pos,
  output logic              hit
);
  localparam int NWIN = DATA_W - PAT_W + 1;
  always_comb begin
    hit = 1'b0;
    for (int p = 0; p < NWIN; p++)
      if (pos == IDX_W'(p) && din[DATA_W-1-p -: PAT_W] == pat) hit = 1'b1;
  end
endmodule

// File: rtl/seq_det_scan.sv
// seq_det_scan: counts pattern occurrences in a word, one window per clk; in clk rst_n start mode pat din, out busy done found match_cnt first_pos
module seq_det_scan
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PAT_W = 2,
  localparam int NWIN = DATA_W - PAT_W + 1,
  localparam int CNT_W = clog2(NWIN + 1),
  localparam int IDX_W = max2(1, clog2(NWIN))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [PAT_W-1:0]  pat,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [IDX_W-1:0]  first_pos
);
  state_t state, state_n;
  logic [DATA_W-1:0] din_q;
  logic [PAT_W-1:0] pat_q;
  logic mode_q, hit, last;
  logic [IDX_W-1:0] pos, first_acc, first_n;
  logic [CNT_W-1:0] cnt_acc, cnt_n;
  logic [31:0] nxt;
  if (PAT_W < 1 || DATA_W < PAT_W) begin : g_bad
    $error("seq_det_scan: requires DATA_W >= PAT_W >= 1");
  end
  seq_win_cmp #(.DATA_W(DATA_W), .PAT_W(PAT_W), .IDX_W(IDX_W)) u_cmp (
    .din(din_q),
    .pat(pat_q),
    .pos(pos),
    .hit(hit)
  );
  // next position is evaluated in 32 bits so a jump past the last window cannot wrap
  always_comb begin
    nxt = 32'(pos) + ((mode_q && hit) ? 32'(PAT_W) : 32'd1);
    last = nxt > 32'(NWIN - 1);
    cnt_n = cnt_acc + CNT_W'(hit);
    first_n = (hit && cnt_acc == '0) ? pos : first_acc;
    state_n = state == ST_IDLE ? (start ? ST_SCAN : ST_IDLE)
            : state == ST_SCAN ? (last ? ST_DONE : ST_SCAN) : ST_IDLE;
  end
  assign busy = state == ST_SCAN;
  assign done = state == ST_DONE;
  always_ff @(posedge clk)
    state <= rst_n ? state_n : ST_IDLE;
  // results are captured on the edge into DONE so they are valid with the done pulse
  always_ff @(posedge clk)
    if (!rst_n) begin
      match_cnt <= '0;
      found <= 1'b0;
      first_pos <= '0;
      pos <= '0;
      cnt_acc <= '0;
      first_acc <= '0;
    end else if (state == ST_IDLE && start) begin
      din_q <= din;
      pat_q <= pat;
      mode_q <= mode;
      pos <= '0;
      cnt_acc <= '0;
      first_acc <= '0;
    end else if (state == ST_SCAN) begin
      pos <= nxt[IDX_W-1:0];
      cnt_acc <= cnt_n;
      first_acc <= first_n;
      if (last) begin
        match_cnt <= cnt_n;
        found <= cnt_n != '0;
        first_pos <= first_n;
      end
    end
endmodule
